// File: rtl/queue_frame_parser_if.sv
// Pixel-queue read port and tagged pixel stream of the frame parser.
// The slave side is the parser; the master side is the queue/framebuffer side.
interface queue_frame_parser_if;
  logic        queue_empty;
  logic [16:0] queue_data;
  logic        queue_rd_en;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        pix_sof;
  logic        pix_eof;

  modport master (
    output queue_empty, queue_data, pix_ready,
    input  queue_rd_en, pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eof
  );

  modport slave (
    input  queue_empty, queue_data, pix_ready,
    output queue_rd_en, pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eof
  );
endinterface

// File: rtl/queue_frame_parser.sv
// Pops 17-bit queue words, decodes FS/RS/FE markers and tags pixels with x/y/sof/eof.
// Latency: queue_rd_en to pix_valid is 2 cycles into an empty buffer; 1 pixel/clk sustained.
// Backpressure: reads are issued only while the 2-entry output buffer has a slot for them.
module queue_frame_parser #(
  parameter int FRAME_WIDTH       = 480,
  parameter int FRAME_HEIGHT      = 272,
  parameter bit EXPECT_EXTRA_DATA = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  queue_frame_parser_if.slave        bus,
  output logic                       frame_done,
  output logic [15:0]                frame_count,
  output logic [3:0]                 err_flags,
  input  logic                       err_clear
);

  localparam logic [10:0] X_LAST = 11'(FRAME_WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {WAIT_FRAME, WAIT_ROW, ROW, WAIT_END} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic        eof;
  } ent_t;

  state_t      r_state;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_inflight;
  ent_t        r_buf [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_frame_done;
  logic [15:0] r_frame_count;
  logic [3:0]  r_err;

  logic        w_marker;
  logic [15:0] w_code;
  logic        w_is_fs;
  logic        w_is_rs;
  logic        w_is_fe;
  logic        w_is_unk;
  logic        w_is_pix;
  logic        w_push;
  logic        w_pop;
  logic        w_complete;
  logic [1:0]  w_occ;
  logic [1:0]  w_outstanding;
  logic [3:0]  w_err_set;
  ent_t        w_head;

  assign w_marker = bus.queue_data[16];
  assign w_code   = bus.queue_data[15:0];
  assign w_is_fs  = r_inflight && w_marker && (w_code == 16'h0000);
  assign w_is_rs  = r_inflight && w_marker && (w_code == 16'h0001);
  assign w_is_fe  = r_inflight && w_marker && (w_code == 16'hFFFF);
  assign w_is_unk = r_inflight && w_marker && !(w_is_fs || w_is_rs || w_is_fe);
  assign w_is_pix = r_inflight && !w_marker;

  assign w_push = w_is_pix && (r_state == ROW);
  assign w_pop  = (r_count != 2'd0) && bus.pix_ready;

  assign w_complete = (!EXPECT_EXTRA_DATA && w_push && (r_x == X_LAST) && (r_y == Y_LAST))
                   || ((r_state == WAIT_END) && w_is_fe);

  // Occupancy is taken after this cycle's pop so a draining buffer keeps 1 pixel/clk.
  assign w_occ           = r_count - {1'b0, w_pop};
  assign w_outstanding   = w_occ + {1'b0, r_inflight};
  assign bus.queue_rd_en = !bus.queue_empty && (w_outstanding < 2'd2);

  assign w_head        = r_buf[r_rd_ptr];
  assign bus.pix_valid = (r_count != 2'd0);
  assign bus.pix_data  = w_head.data;
  assign bus.pix_x     = w_head.x;
  assign bus.pix_y     = w_head.y;
  assign bus.pix_sof   = w_head.sof;
  assign bus.pix_eof   = w_head.eof;

  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign err_flags   = r_err;

  always_comb begin
    w_err_set = 4'b0000;
    if (w_is_unk) w_err_set[0] = 1'b1;
    if (w_is_fs && (r_state != WAIT_FRAME)) w_err_set[3] = 1'b1;
    case (r_state)
      WAIT_FRAME: if (w_is_pix || w_is_rs) w_err_set[0] = 1'b1;
      WAIT_ROW: begin
        if (w_is_pix) w_err_set[2] = 1'b1;
        if (w_is_fe)  w_err_set[3] = 1'b1;
      end
      ROW: begin
        if (w_is_rs && (r_x != 11'd0)) w_err_set[1] = 1'b1;
        if (w_is_fe)                   w_err_set[3] = 1'b1;
      end
      WAIT_END: if (w_is_pix || w_is_rs) w_err_set[2] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= bus.queue_rd_en;
      if (w_push) begin
        r_buf[r_wr_ptr] <= '{data: bus.queue_data[15:0], x: r_x, y: r_y,
                             sof: (r_x == 11'd0) && (r_y == 11'd0),
                             eof: (r_x == X_LAST) && (r_y == Y_LAST)};
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= WAIT_FRAME;
      r_x           <= 11'd0;
      r_y           <= 11'd0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
      r_err         <= 4'b0000;
    end else begin
      r_frame_done <= w_complete;
      if (w_complete) r_frame_count <= r_frame_count + 16'd1;
      r_err <= err_clear ? 4'b0000 : (r_err | w_err_set);

      if (w_is_fs) begin
        r_x     <= 11'd0;
        r_y     <= 11'd0;
        r_state <= EXPECT_EXTRA_DATA ? WAIT_ROW : ROW;
      end else begin
        case (r_state)
          WAIT_ROW: begin
            if (w_is_rs)      r_state <= ROW;
            else if (w_is_fe) r_state <= WAIT_FRAME;
          end
          ROW: begin
            if (w_is_pix) begin
              if (r_x == X_LAST) begin
                r_x <= 11'd0;
                if (r_y == Y_LAST) begin
                  r_y     <= 11'd0;
                  r_state <= EXPECT_EXTRA_DATA ? WAIT_END : WAIT_FRAME;
                end else begin
                  r_y     <= r_y + 11'd1;
                  r_state <= EXPECT_EXTRA_DATA ? WAIT_ROW : ROW;
                end
              end else begin
                r_x <= r_x + 11'd1;
              end
            end else if (w_is_rs && (r_x != 11'd0)) begin
              // Aborted row: the RS itself opens the next row.
              r_x <= 11'd0;
              if (r_y == Y_LAST) r_state <= WAIT_END;
              else               r_y     <= r_y + 11'd1;
            end else if (w_is_fe) begin
              r_state <= WAIT_FRAME;
            end
          end
          WAIT_END: begin
            if (w_is_fe) begin
              r_y     <= 11'd0;
              r_state <= WAIT_FRAME;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_queue_frame_parser.sv
// Directed bench for queue_frame_parser: an 8x4 frame in extra-marker and FS-only modes,
// with a queue model on the read side and a pixel collector on the output side.
module tb_queue_frame_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic pix_ready;
  logic err_clear;
  logic flush;

  queue_frame_parser_if ife ();
  queue_frame_parser_if ifn ();

  logic        fd_e, fd_n;
  logic [15:0] fc_e, fc_n;
  logic [3:0]  err_e, err_n;

  queue_frame_parser #(.FRAME_WIDTH(8), .FRAME_HEIGHT(4), .EXPECT_EXTRA_DATA(1'b1)) u_ext (
    .clk(clk), .reset_n(reset_n), .bus(ife),
    .frame_done(fd_e), .frame_count(fc_e), .err_flags(err_e), .err_clear(err_clear));

  queue_frame_parser #(.FRAME_WIDTH(8), .FRAME_HEIGHT(4), .EXPECT_EXTRA_DATA(1'b0)) u_nx (
    .clk(clk), .reset_n(reset_n), .bus(ifn),
    .frame_done(fd_n), .frame_count(fc_n), .err_flags(err_n), .err_clear(err_clear));

  // Queue model: one-cycle read latency, per-DUT word store.
  logic [16:0] mem [2][512];
  logic [8:0]  wr_n [2];
  logic [8:0]  rd_n [2] = '{9'd0, 9'd0};
  logic [16:0] qdata [2] = '{17'd0, 17'd0};
  logic        rd_en [2];

  assign rd_en[0] = ife.queue_rd_en;
  assign rd_en[1] = ifn.queue_rd_en;
  assign ife.queue_empty = (rd_n[0] == wr_n[0]);
  assign ifn.queue_empty = (rd_n[1] == wr_n[1]);
  assign ife.queue_data  = qdata[0];
  assign ifn.queue_data  = qdata[1];
  assign ife.pix_ready   = pix_ready;
  assign ifn.pix_ready   = pix_ready;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (flush) rd_n[d] <= wr_n[d];
      else if (rd_en[d]) begin
        qdata[d] <= mem[d][rd_n[d]];
        rd_n[d]  <= rd_n[d] + 9'd1;
      end
    end
  end

  // Collector: handshakes sampled mid-cycle, frame_done pulses counted.
  logic [39:0] out_e [$];
  logic [39:0] out_n [$];
  int fd [2] = '{0, 0};

  always @(negedge clk) begin
    if (ife.pix_valid && pix_ready)
      out_e.push_back({ife.pix_data, ife.pix_x, ife.pix_y, ife.pix_sof, ife.pix_eof});
    if (ifn.pix_valid && pix_ready)
      out_n.push_back({ifn.pix_data, ifn.pix_x, ifn.pix_y, ifn.pix_sof, ifn.pix_eof});
    fd[0] <= fd[0] + (fd_e ? 1 : 0);
    fd[1] <= fd[1] + (fd_n ? 1 : 0);
  end

  typedef struct {
    logic [16:0] word;
    logic        is_pix;
    logic [39:0] exp;
  } vec_t;

  vec_t tbl [38];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [39:0] pix_exp(input int x, input int y);
    logic [15:0] dat;
    dat = 16'h5000 | 16'(y * 256 + x);
    return {dat, 11'(x), 11'(y), 1'(x == 0 && y == 0), 1'(x == 7 && y == 3)};
  endfunction

  function automatic int out_size(input int d);
    return (d == 0) ? out_e.size() : out_n.size();
  endfunction

  function automatic logic [39:0] get_out(input int d, input int i);
    if (i >= out_size(d)) return '1;
    return (d == 0) ? out_e[i] : out_n[i];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [16:0] w);
    mem[d][wr_n[d]] = w;
    wr_n[d] = wr_n[d] + 9'd1;
  endtask

  task automatic push_tbl(input int d, input int from, input int to);
    for (int i = from; i <= to; i++) push(d, tbl[i].word);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd(input int d, input int target, input string name);
    int k;
    k = 0;
    while (fd[d] < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(fd[d]), 64'(target));
  endtask

  task automatic cmp_stream(input int d, input int base, input string name);
    int k;
    k = 0;
    for (int i = 0; i < 38; i++) begin
      if (tbl[i].is_pix) begin
        check($sformatf("%s px%0d", name, k), 64'(get_out(d, base + k)), 64'(tbl[i].exp));
        k++;
      end
    end
    check({name, " count"}, 64'(out_size(d) - base), 64'd32);
  endtask

  task automatic clear_err();
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n, base, rds, k;
    logic [39:0] e;

    // FS, 4 x (RS + 8 pixels), FE with the expected tagged pixel for every pixel word.
    n = 0;
    tbl[n] = '{17'h10000, 1'b0, 40'd0}; n++;
    for (int y = 0; y < 4; y++) begin
      tbl[n] = '{17'h10001, 1'b0, 40'd0}; n++;
      for (int x = 0; x < 8; x++) begin
        e = pix_exp(x, y);
        tbl[n] = '{{1'b0, e[39:24]}, 1'b1, e}; n++;
      end
    end
    tbl[n] = '{17'h1FFFF, 1'b0, 40'd0};

    wr_n[0] = 9'd0;
    wr_n[1] = 9'd0;
    reset_n   = 1'b0;
    pix_ready = 1'b1;
    err_clear = 1'b0;
    flush     = 1'b0;
    cyc(3);
    check("rst pix_valid",   64'(ife.pix_valid),   64'd0);
    check("rst queue_rd_en", 64'(ife.queue_rd_en), 64'd0);
    check("rst frame_count", 64'(fc_e),            64'd0);
    check("rst err_flags",   64'(err_e),           64'd0);
    check("rst frame_done",  64'(fd_e),            64'd0);
    check("rst pix_xy",      64'({ife.pix_x, ife.pix_y}), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    cyc(2);

    // Nominal extra-marker frame.
    base = out_size(0);
    push_tbl(0, 0, 37);
    wait_fd(0, 1, "t1 frame_done");
    cyc(4);
    cmp_stream(0, base, "t1");
    check("t1 frame_done once", 64'(fd[0]), 64'd1);
    check("t1 frame_count", 64'(fc_e),  64'd1);
    check("t1 err_flags",   64'(err_e), 64'd0);

    // FS-only mode: completion on pixel (7,3), then a second frame.
    for (int f = 1; f <= 2; f++) begin
      base = out_size(1);
      push(1, 17'h10000);
      for (int i = 0; i < 38; i++) if (tbl[i].is_pix) push(1, tbl[i].word);
      wait_fd(1, f, $sformatf("t2 f%0d frame_done", f));
      cyc(4);
      cmp_stream(1, base, $sformatf("t2 f%0d", f));
      check($sformatf("t2 f%0d frame_count", f), 64'(fc_n), 64'(f));
    end
    check("t2 err_flags", 64'(err_n), 64'd0);

    // Read-to-valid latency, then a 10-cycle stall mid-frame.
    base = out_size(0);
    push(0, tbl[0].word);
    push(0, tbl[1].word);
    cyc(4);
    push(0, tbl[2].word);
    #1 check("lat rd_en", 64'(ife.queue_rd_en), 64'd1);
    @(negedge clk); check("lat n+1 valid", 64'(ife.pix_valid), 64'd0);
    @(negedge clk); check("lat n+2 valid", 64'(ife.pix_valid), 64'd1);
    push_tbl(0, 3, 37);
    cyc(12);
    @(posedge clk); #1 pix_ready = 1'b0;
    rds = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ife.queue_rd_en) rds++;
    end
    check("bp reads bounded", 64'(rds <= 2), 64'd1);
    check("bp rd_en low",     64'(ife.queue_rd_en), 64'd0);
    check("bp valid held",    64'(ife.pix_valid),   64'd1);
    @(posedge clk); #1 pix_ready = 1'b1;
    wait_fd(0, 2, "t3 frame_done");
    cyc(4);
    cmp_stream(0, base, "t3");
    check("t3 frame_count", 64'(fc_e), 64'd2);

    // Short row: RS after 5 pixels of row 1.
    base = out_size(0);
    push_tbl(0, 0, 9);
    push(0, tbl[10].word);
    push_tbl(0, 11, 15);
    push(0, 17'h10001);
    push_tbl(0, 20, 21);
    cyc(40);
    check("short count", 64'(out_size(0) - base), 64'd15);
    check("short px13",  64'(get_out(0, base + 13)), 64'(tbl[20].exp));
    check("short px14",  64'(get_out(0, base + 14)), 64'(tbl[21].exp));
    check("short err",   64'(err_e), 64'b0010);
    clear_err();
    check("short err clear", 64'(err_e), 64'd0);

    // FS mid-frame (row 2) restarts at (0,0) with sof.
    push(0, 17'h10000);
    push(0, 17'h10001);
    push(0, tbl[2].word);
    cyc(8);
    check("resync err",   64'(err_e), 64'b1000);
    check("resync count", 64'(out_size(0) - base), 64'd16);
    check("resync px",    64'(get_out(0, base + 15)), 64'(tbl[2].exp));
    push(0, 17'h1FFFF);
    cyc(4);
    clear_err();

    // Garbage outside a frame: pixels, unknown marker, RS.
    base = out_size(0);
    push(0, tbl[2].word);
    push(0, tbl[3].word);
    push(0, 17'h10005);
    push(0, 17'h10001);
    cyc(8);
    check("garbage err",      64'(err_e), 64'b0001);
    check("garbage no pixel", 64'(out_size(0) - base), 64'd0);
    clear_err();

    // Reset with a word in flight, then a clean frame.
    push_tbl(0, 0, 9);
    k = 0;
    while (!ife.queue_rd_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst2 saw read", 64'(ife.queue_rd_en), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    flush   = 1'b1;
    cyc(2);
    check("rst2 pix_valid",   64'(ife.pix_valid),   64'd0);
    check("rst2 queue_rd_en", 64'(ife.queue_rd_en), 64'd0);
    check("rst2 pix head",    64'({ife.pix_data, ife.pix_x, ife.pix_y, ife.pix_sof, ife.pix_eof}), 64'd0);
    check("rst2 frame_count", 64'(fc_e),  64'd0);
    check("rst2 err_flags",   64'(err_e), 64'd0);
    check("rst2 frame_done",  64'(fd_e),  64'd0);
    flush = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    cyc(2);
    base = out_size(0);
    push_tbl(0, 0, 37);
    wait_fd(0, 3, "rst2 frame_done");
    cyc(4);
    cmp_stream(0, base, "rst2");
    check("rst2 frame_count after", 64'(fc_e),  64'd1);
    check("rst2 err after",         64'(err_e), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/queue_frame_parser.md
Name: queue_frame_parser

Overview:
- Consumer stage on the read side of the 17-bit pixel queue fed by the debug pattern generator or the camera capture path.
- Pops queue words, decodes the control markers, and tracks row and column position.
- Emits a ready/valid pixel stream tagged with x/y coordinates and start/end-of-frame flags toward the framebuffer writer.
- Detects framing protocol violations and reports them as sticky error flags, then resynchronises on the next frame start.

Parameters:
FRAME_WIDTH, 480, pixels per row.
FRAME_HEIGHT, 272, rows per frame.
EXPECT_EXTRA_DATA, 1'b1, 1: the stream carries row-start (17'h10001) and frame-end (17'h1FFFF) markers; 0: only the frame-start marker is present.

Ports:
clk  in  1  single clock domain; the queue read clock is tied to it.
reset_n  in  1  asynchronous, active-low reset.
queue_empty  in  1  queue has no readable word.
queue_data  in  17  word read from the queue, valid the cycle after queue_rd_en.
queue_rd_en  out  1  pop request.
pix_valid  out  1  output pixel valid.
pix_ready  in  1  downstream accepts the pixel.
pix_data  out  16  RGB565 pixel.
pix_x  out  11  column index.
pix_y  out  11  row index.
pix_sof  out  1  pixel is (0,0).
pix_eof  out  1  pixel is (FRAME_WIDTH-1, FRAME_HEIGHT-1).
frame_done  out  1  one-cycle pulse when a frame completes.
frame_count  out  16  number of completed frames, wraps at 16'hFFFF to 0.
err_flags  out  4  sticky error bits: [0] sync/unknown marker, [1] short row, [2] long row/extra pixel, [3] short frame.
err_clear  in  1  clears err_flags for one cycle.

Behaviour:
- Reset values: all outputs 0, state WAIT_FRAME, x=y=0, output buffer empty, no read in flight.
- Read timing: one-cycle read latency. queue_rd_en in cycle N means queue_data is decoded in cycle N+1.
- Read issue rule: queue_rd_en = !queue_empty && (buffer occupancy + reads in flight) < 2. Markers are consumed at decode and take no buffer slot.
- Output buffer:
  - 2-entry FIFO of {data, x, y, sof, eof}. The head drives the pix_* outputs.
  - A pop occurs on pix_valid && pix_ready.
  - Pixel latency is rd_en N to pix_valid N+2 when the buffer was empty.
  - Sustained throughput is 1 pixel/clk when pix_ready is held high.
- Decode: bit16=1 is a marker (0x0000 FS, 0x0001 RS, 0xFFFF FE; any other value is unknown: set err[0] and drop). bit16=0 is a pixel.
- FS in any state:
  - Set x=y=0.
  - Go to WAIT_ROW if EXPECT_EXTRA_DATA, else ROW.
  - If the state was not WAIT_FRAME, set err[3].
- State machine:
  - WAIT_FRAME: pixels, RS and FE are dropped; pixels and RS set err[0].
  - WAIT_ROW: on RS go to ROW. A pixel is dropped and sets err[2]. FE sets err[3] and returns to WAIT_FRAME.
  - ROW:
    - A pixel is pushed with the current x,y, then x increments.
    - When x==FRAME_WIDTH-1 is pushed, set x=0. If y==FRAME_HEIGHT-1, go to WAIT_END (extra mode) or complete the frame (non-extra mode). Otherwise y increments and the state goes to WAIT_ROW (extra mode) or stays in ROW (non-extra mode).
    - RS with x!=0: set err[1], abort the row (x=0, y increments), stay in ROW. If the aborted row was the last row, go to WAIT_END instead.
    - RS with x==0 is accepted silently.
    - FE: set err[3] and go to WAIT_FRAME.
  - WAIT_END: FE completes the frame. A pixel is dropped and sets err[2]. RS sets err[2].
- Frame complete:
  - frame_done pulses for one cycle in the cycle after decode.
  - frame_count increments.
  - State returns to WAIT_FRAME.
  - frame_done is independent of buffer drain; the stream marks frame end with pix_eof.
- Arithmetic: x and y are 11-bit and never exceed FRAME_WIDTH-1 or FRAME_HEIGHT-1.
- Errors: err_flags bits OR in new events. err_clear has priority over a same-cycle set; the event is lost.
- Backpressure: the read-issue rule guarantees the buffer never overflows. Words already in flight always have a slot.
- A reset mid-frame discards the buffer and any in-flight word, and returns to WAIT_FRAME.

Test Plan:
- Nominal, extra mode, 8x4 frame, pix_ready=1: FS, 4×(RS+8 pixels), FE produce 32 pixels with x 0..7 and y 0..3. sof is set on the first pixel, eof on the last. frame_done pulses once, frame_count=1, err_flags=0.
- Non-extra mode, 8x4: FS plus 32 pixels gives frame_done after pixel (7,3) is decoded, with no FE needed. A second FS starts frame 2 and frame_count=2.
- Backpressure: hold pix_ready=0 for 10 cycles mid-row. queue_rd_en drops after at most 2 outstanding words, no pixel is lost or duplicated, and the x sequence stays contiguous.
- Short row: RS after 5 pixels of row 1 sets err_flags=4'b0010. Next pixels are tagged y=2, x=0. err_clear returns err_flags to 0.
- Garbage and resync: pixels and 17'h10005 before FS set err[0] with no pix_valid. FS arriving mid-frame at row 2 sets err[3] and restarts at (0,0) with sof.
- Reset asserted mid-row with a word in flight: all outputs are 0 and state is WAIT_FRAME. After release, the next FS frame parses cleanly.
